// File: rtl/fixed_div_pkg.sv
// rtl/fixed_div_pkg.sv - Shared types and helpers for the fixed-point divider
//
// Contents:
//   div_state_t          - divider FSM states (IDLE, CALC, FIX, DONE)
//   div_latency()        - accept-edge to result-cycle latency for a configuration
//   DIV_LATENCY_DEFAULT  - latency for the default 16.16 configuration
//   abs_ext()            - magnitude of a sign-extended MAX_W-bit value
//   sat_max()/sat_min()  - most positive / most negative w-bit two's-complement patterns
package fixed_div_pkg;

    // Helpers work on a wide common width; callers size-cast the result.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    // One CALC cycle per quotient bit, plus FIX, then the DONE cycle carries the pulse.
    function automatic int div_latency(input int width, input int frac_bits);
        return width + frac_bits + 1;
    endfunction

    localparam int DIV_LATENCY_DEFAULT = div_latency(16, 16);

    function automatic logic [MAX_W-1:0] abs_ext(input logic signed [MAX_W-1:0] v);
        return v[MAX_W-1] ? unsigned'(-v) : unsigned'(v);
    endfunction

    function automatic logic [MAX_W-1:0] sat_max(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/fixed_point_divider.sv
// rtl/fixed_point_divider.sv - Sequential signed fixed-point restoring divider
//
// Ports:
//   clk                     - rising-edge clock
//   rst_n                   - asynchronous active-low reset
//   s_axis_dividend_tdata   - signed dividend, WIDTH bits
//   s_axis_dividend_tvalid  - dividend valid
//   s_axis_divisor_tdata    - signed divisor, WIDTH bits
//   s_axis_divisor_tvalid   - divisor valid
//   m_axis_dout_tdata       - signed quotient Q(WIDTH).(FRAC_BITS), held until next result
//   m_axis_dout_tvalid      - one-cycle result pulse
//   m_axis_dout_tuser       - [0] divide-by-zero, [1] overflow
//
// No tready: a pair is taken only when IDLE with both valids high; anything
// presented while busy is simply ignored.
module fixed_point_divider
    import fixed_div_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           s_axis_dividend_tdata,
    input  logic                       s_axis_dividend_tvalid,
    input  logic [WIDTH-1:0]           s_axis_divisor_tdata,
    input  logic                       s_axis_divisor_tvalid,
    output logic [WIDTH+FRAC_BITS-1:0] m_axis_dout_tdata,
    output logic                       m_axis_dout_tvalid,
    output logic [1:0]                 m_axis_dout_tuser
);

    localparam int RW    = WIDTH + FRAC_BITS;
    localparam int CNT_W = $clog2(RW + 1);

    div_state_t       state;
    logic             sign_q;
    logic             zero_q;
    logic [WIDTH:0]   b_abs_q;
    logic [WIDTH:0]   rem_q;
    logic [RW-1:0]    quo_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic [WIDTH:0]   a_abs;
    logic [WIDTH:0]   b_abs;
    logic [WIDTH:0]   trial;
    logic             take;
    logic [RW-1:0]    quo_signed;
    logic [RW-1:0]    fix_data;
    logic [1:0]       fix_user;
    logic             unused_rem_msb;

    assign accept = (state == ST_IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

    // WIDTH+1-bit magnitudes so that -2^(WIDTH-1) is representable.
    assign a_abs = (WIDTH+1)'(abs_ext(MAX_W'(signed'(s_axis_dividend_tdata))));
    assign b_abs = (WIDTH+1)'(abs_ext(MAX_W'(signed'(s_axis_divisor_tdata))));

    // quo_q starts as the numerator |a|<<FRAC_BITS; its MSB feeds the remainder
    // while quotient bits enter at the LSB, so after RW shifts it holds the quotient.
    // For a nonzero divisor the remainder stays below |b| <= 2^(WIDTH-1), so its
    // top bit is never needed; with a zero divisor it overflows harmlessly and the
    // result is overridden in FIX anyway.
    assign trial          = {rem_q[WIDTH-1:0], quo_q[RW-1]};
    assign take           = (trial >= b_abs_q);
    assign unused_rem_msb = rem_q[WIDTH];

    always_comb begin
        quo_signed = sign_q ? (~quo_q + RW'(1)) : quo_q;
        fix_data   = quo_signed;
        fix_user   = 2'b00;
        if (zero_q) begin
            // With b == 0, sign_q is just the dividend's sign.
            fix_data = sign_q ? RW'(sat_min(RW)) : RW'(sat_max(RW));
            fix_user = 2'b01;
        end else if (!sign_q && quo_q[RW-1]) begin
            // Only -2^(WIDTH-1) / -1 yields a positive magnitude of 2^(RW-1).
            fix_data = RW'(sat_max(RW));
            fix_user = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            sign_q             <= 1'b0;
            zero_q             <= 1'b0;
            b_abs_q            <= '0;
            rem_q              <= '0;
            quo_q              <= '0;
            cnt_q              <= '0;
            m_axis_dout_tdata  <= '0;
            m_axis_dout_tvalid <= 1'b0;
            m_axis_dout_tuser  <= 2'b00;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sign_q  <= s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1];
                        zero_q  <= (s_axis_divisor_tdata == '0);
                        b_abs_q <= b_abs;
                        rem_q   <= '0;
                        quo_q   <= RW'(a_abs) << FRAC_BITS;
                        cnt_q   <= '0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem_q <= take ? (trial - b_abs_q) : trial;
                    quo_q <= {quo_q[RW-2:0], take};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(RW - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    m_axis_dout_tdata  <= fix_data;
                    m_axis_dout_tuser  <= fix_user;
                    m_axis_dout_tvalid <= 1'b1;
                    state              <= ST_DONE;
                end
                ST_DONE: begin
                    m_axis_dout_tvalid <= 1'b0;
                    state              <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divider.sv
// tb/tb_fixed_point_divider.sv - Self-checking bench for fixed_point_divider
module tb_fixed_point_divider;

    localparam int LAT = 33;

    logic               clk;
    logic               rst_n;
    logic signed [15:0] dvd;
    logic               dvd_valid;
    logic signed [15:0] dvs;
    logic               dvs_valid;
    logic [31:0]        dout;
    logic               tvalid;
    logic [1:0]         tuser;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    fixed_point_divider dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .s_axis_dividend_tdata  (dvd),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_divisor_tdata   (dvs),
        .s_axis_divisor_tvalid  (dvs_valid),
        .m_axis_dout_tdata      (dout),
        .m_axis_dout_tvalid     (tvalid),
        .m_axis_dout_tuser      (tuser)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical definition.
    function automatic void model_div(input logic signed [15:0] a, input logic signed [15:0] b,
                                      output logic [31:0] d, output logic [1:0] u);
        longint n;
        longint q;
        if (b == 16'sd0) begin
            d = (a < 16'sd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            u = 2'b01;
        end else begin
            n = longint'(a) * 65536;
            q = n / longint'(b);
            if (q > 64'sd2147483647) begin
                d = 32'h7FFF_FFFF;
                u = 2'b10;
            end else begin
                d = q[31:0];
                u = 2'b00;
            end
        end
    endfunction

    // Transaction-level model: when a pair is taken, when its result appears, what is held.
    int          cyc = 0;
    int          m_next_free = 0;
    bit          m_pend = 0;
    int          m_pend_cyc = 0;
    logic [31:0] m_pend_data = '0;
    logic [1:0]  m_pend_user = '0;
    logic [31:0] m_data = '0;
    logic [1:0]  m_user = '0;
    logic        m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend      = 0;
            m_valid     = 1'b0;
            m_data      = '0;
            m_user      = '0;
            m_next_free = 0;
        end else begin
            cyc++;
            m_valid = 1'b0;
            if (m_pend && cyc == m_pend_cyc) begin
                m_data  = m_pend_data;
                m_user  = m_pend_user;
                m_valid = 1'b1;
                m_pend  = 0;
            end
            if (cyc >= m_next_free && dvd_valid && dvs_valid) begin
                model_div(dvd, dvs, m_pend_data, m_pend_user);
                m_pend      = 1;
                m_pend_cyc  = cyc + LAT;
                m_next_free = cyc + LAT + 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp tvalid", 64'(tvalid), 64'(m_valid));
            check("cmp tdata", 64'(dout), 64'(m_data));
            check("cmp tuser", 64'(tuser), 64'(m_user));
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_op(input string nm, input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic [31:0] lit_d, input logic [1:0] lit_u);
        logic [31:0] md;
        logic [1:0]  mu;
        logic [31:0] got_d;
        logic [1:0]  got_u;
        int          lat;
        model_div(a, b, md, mu);
        check({nm, " model"}, {30'd0, mu, md}, {30'd0, lit_u, lit_d});
        #1;
        dvd = a; dvs = b; dvd_valid = 1'b1; dvs_valid = 1'b1;
        @(posedge clk);
        #1;
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        dvd = ~a; dvs = 16'sh0001;
        lat = -1; got_d = '0; got_u = '0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (tvalid) begin
                lat = j; got_d = dout; got_u = tuser;
                break;
            end
        end
        check({nm, " latency"}, 64'(lat), 64'(LAT));
        check({nm, " tdata"}, 64'(got_d), 64'(lit_d));
        check({nm, " tuser"}, 64'(got_u), 64'(lit_u));
        @(negedge clk);
        check({nm, " pulse width"}, 64'(tvalid), 64'd0);
    endtask

    initial begin
        int          npulse;
        int          t1;
        int          t2;
        logic [31:0] d1;
        logic [31:0] d2;

        rst_n = 1'b0;
        dvd = '0; dvs = '0; dvd_valid = 1'b0; dvs_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tvalid", 64'(tvalid), 64'd0);
        check("reset tdata", 64'(dout), 64'd0);
        check("reset tuser", 64'(tuser), 64'd0);
        #1 rst_n = 1'b1;
        chk_en = 1;
        @(negedge clk);

        run_op("7/2",        16'sd7,      16'sd2,  32'h0003_8000, 2'b00);
        run_op("-1/3",      -16'sd1,      16'sd3,  32'hFFFF_AAAB, 2'b00);
        run_op("-7/2",      -16'sd7,      16'sd2,  32'hFFFC_8000, 2'b00);
        run_op("5/0",        16'sd5,      16'sd0,  32'h7FFF_FFFF, 2'b01);
        run_op("-5/0",      -16'sd5,      16'sd0,  32'h8000_0000, 2'b01);
        run_op("min/-1",     16'sh8000,   16'shFFFF, 32'h7FFF_FFFF, 2'b10);
        run_op("min/1",      16'sh8000,   16'sd1,  32'h8000_0000, 2'b00);
        run_op("0/-5",       16'sd0,     -16'sd5,  32'h0000_0000, 2'b00);
        run_op("max/min",    16'sh7FFF,   16'sh8000, 32'hFFFF_0002, 2'b00);

        // Back-to-back with valids held high and operands changed mid-CALC.
        #1;
        dvd = 16'sd6; dvs = 16'sd3; dvd_valid = 1'b1; dvs_valid = 1'b1;
        @(posedge clk);
        npulse = 0; t1 = -1; t2 = -1; d1 = '0; d2 = '0;
        for (int j = 0; j < 76; j++) begin
            @(negedge clk);
            if (tvalid) begin
                if (npulse == 0) begin t1 = j; d1 = dout; end
                else begin t2 = j; d2 = dout; end
                npulse++;
            end
            if (j == 50) check("b2b hold", 64'(dout), 64'h0002_0000);
            if (j == 5) begin #1 dvd = 16'sd9; end
            if (j == 35) begin #1 dvd_valid = 1'b0; dvs_valid = 1'b0; end
        end
        check("b2b pulses", 64'(npulse), 64'd2);
        check("b2b t1", 64'(t1), 64'(LAT));
        check("b2b d1", 64'(d1), 64'h0002_0000);
        check("b2b t2", 64'(t2), 64'(2 * LAT + 2));
        check("b2b d2", 64'(d2), 64'h0003_0000);

        // Reset in the middle of CALC discards the operation.
        #1;
        dvd = 16'sd100; dvs = 16'sd7; dvd_valid = 1'b1; dvs_valid = 1'b1;
        @(posedge clk);
        #1 dvd_valid = 1'b0; dvs_valid = 1'b0;
        repeat (11) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid reset tvalid", 64'(tvalid), 64'd0);
        check("mid reset tdata", 64'(dout), 64'd0);
        check("mid reset tuser", 64'(tuser), 64'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        npulse = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (tvalid) npulse++;
        end
        check("post reset no pulse", 64'(npulse), 64'd0);
        run_op("4/2 after reset", 16'sd4, 16'sd2, 32'h0002_0000, 2'b00);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
